// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a DEPTH-entry word FIFO feeding a frame shifter
// that sends start, WIDTH data bits (LSB first), optional parity and one or
// two stop bits at a runtime-selectable bit period.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [15:0]                  clock_divider,
  input  logic [1:0]                   parity_mode,
  input  logic                         stop_bits,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         write_en,
  output logic                         data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy,
  output logic                         tx
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  state_t           state;
  logic [15:0]      baud_cnt;
  logic [15:0]      div_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             stop_q;
  logic [WIDTH-1:0] shifter;
  logic [BW-1:0]    bit_cnt;

  logic             push;
  logic             pop;
  logic             bit_tick;
  logic             frame_done;
  logic [WIDTH-1:0] head;

  // Status flags and handshake decode; data_ready depends only on the count
  // register, so a same-cycle pop never frees a slot for a same-cycle write.
  // NOTE: every always_comb output gets a value on every path, otherwise a
  // latch is inferred.
  always_comb begin
    data_ready = (fifo_count != CW'(DEPTH));
    busy       = (state != IDLE);
    bit_tick   = (baud_cnt == div_q);
    frame_done = (state == STOP) && bit_tick && (bit_cnt == BW'(stop_q));
    push       = write_en && data_ready;
    pop        = (fifo_count != '0) && ((state == IDLE) || frame_done);
    head       = mem[rd_ptr];
  end

  // FIFO storage write port.
  // NOTE: the storage array carries no reset; the pointers and count define
  // which entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer: loads a word on pop, then steps start/data/parity/stop
  // every div_q+1 cycles, driving a registered tx.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 1'b0;
      shifter   <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
    end else if (pop) begin
      // Configuration is latched here and held for the whole frame.
      state     <= START;
      baud_cnt  <= '0;
      div_q     <= clock_divider;
      par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_q <= (^head) ^ (parity_mode == 2'b10);
      stop_q    <= stop_bits;
      shifter   <= head;
      bit_cnt   <= '0;
      tx        <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_tick) begin
        baud_cnt <= baud_cnt + 16'd1;
      end else begin
        baud_cnt <= '0;
        unique case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shifter[0];
          end
          DATA: begin
            if (bit_cnt == BW'(WIDTH - 1)) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state <= PARITY;
                tx    <= par_bit_q;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shifter <= shifter >> 1;
              tx      <= shifter[1];
            end
          end
          PARITY: begin
            state   <= STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end
          STOP: begin
            // Last stop bit with an empty FIFO: return to idle.
            if (bit_cnt == BW'(stop_q)) begin
              state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
            tx <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based model turns each popped
// word into its expected per-cycle tx waveform, compared every cycle, plus
// directed scenarios with explicit frame-length and bit-value expectations.
module tb_uart_tx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset_n;
  logic [15:0]      clock_divider;
  logic [1:0]       parity_mode;
  logic             stop_bits;
  logic [WIDTH-1:0] data_in;
  logic             write_en;
  logic             data_ready;
  logic [CW-1:0]    fifo_count;
  logic             busy;
  logic             tx;

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .data_in       (data_in),
    .write_en      (write_en),
    .data_ready    (data_ready),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .tx            (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: words waiting in the FIFO, and the remaining expected
  // tx values (one per clock cycle) of the frame currently on the line.
  logic [WIDTH-1:0] mq[$];
  logic             wave[$];
  logic             m_ready;

  task automatic build_frame(input logic [WIDTH-1:0] w);
    int n;
    logic p;
    n = int'(clock_divider) + 1;
    repeat (n) wave.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) repeat (n) wave.push_back(w[i]);
    if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
      p = (^w) ^ (parity_mode == 2'b10);
      repeat (n) wave.push_back(p);
    end
    repeat (n * (stop_bits ? 2 : 1)) wave.push_back(1'b1);
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      wave.delete();
    end else begin
      m_ready = (mq.size() < DEPTH);
      if (wave.size() > 0) void'(wave.pop_front());
      if (wave.size() == 0 && mq.size() > 0) build_frame(mq.pop_front());
      if (write_en && m_ready) mq.push_back(data_in);
    end
  end

  // Per-cycle comparison against the model, plus busy-length and tx capture.
  int   busy_acc;
  logic cap[$];

  always @(negedge clock) begin
    check("tx",    tx,         (wave.size() > 0) ? wave[0] : 1'b1);
    check("busy",  busy,       wave.size() > 0);
    check("count", fifo_count, mq.size());
    check("ready", data_ready, mq.size() < DEPTH);
    if (busy) begin
      busy_acc++;
      cap.push_back(tx);
    end
  end

  task automatic write_word(input logic [WIDTH-1:0] w);
    @(negedge clock);
    data_in  = w;
    write_en = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clock);
      if (!busy && fifo_count == '0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL idle_timeout: still busy after %0d cycles", limit);
    end
  endtask

  task automatic start_frame_test(input logic [15:0] div, input logic [1:0] pm, input logic sb);
    clock_divider = div;
    parity_mode   = pm;
    stop_bits     = sb;
    busy_acc      = 0;
    cap.delete();
  endtask

  logic [7:0] a5;

  initial begin
    reset_n       = 1'b0;
    write_en      = 1'b0;
    data_in       = '0;
    clock_divider = 16'd3;
    parity_mode   = 2'b00;
    stop_bits     = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_tx",    tx,         1);
    check("rst_busy",  busy,       0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", data_ready, 1);
    reset_n = 1'b1;

    // 0xA5, divider 3, no parity, one stop bit: 10 bits of 4 cycles.
    start_frame_test(16'd3, 2'b00, 1'b0);
    write_word(8'hA5);
    wait_idle(200);
    check("a5_busy_len", busy_acc, 40);
    a5 = 8'hA5;
    check("a5_start", cap[1], 0);
    for (int i = 0; i < 8; i++) check("a5_bit", cap[4 * (1 + i) + 2], a5[i]);
    check("a5_stop", cap[38], 1);

    // Parity with divider 0 on 0x07 (three ones).
    start_frame_test(16'd0, 2'b01, 1'b0);
    write_word(8'h07);
    wait_idle(100);
    check("even_len", busy_acc, 11);
    check("even_bit", cap[9], 1);

    start_frame_test(16'd0, 2'b10, 1'b0);
    write_word(8'h07);
    wait_idle(100);
    check("odd_len", busy_acc, 11);
    check("odd_bit", cap[9], 0);

    start_frame_test(16'd0, 2'b01, 1'b1);
    write_word(8'h07);
    wait_idle(100);
    check("even2stop_len", busy_acc, 12);

    // Fill: six consecutive writes, divider 9; the sixth is dropped.
    start_frame_test(16'd9, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 2) check("fill_first_pop", busy, 1);
      if (i == 5) check("fill_ready_low", data_ready, 0);
      data_in  = 8'h10 + 8'(i);
      write_en = 1'b1;
    end
    @(negedge clock);
    write_en = 1'b0;
    check("fill_count", fifo_count, 4);
    wait_idle(1000);
    check("fill_busy_len", busy_acc, 500);

    // Full boundary: write on the exact pop cycle while full is dropped.
    start_frame_test(16'd2, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      data_in  = 8'($urandom);
      write_en = 1'b1;
    end
    @(negedge clock);
    write_en = 1'b0;
    check("full_count", fifo_count, 4);
    for (int i = 0; i < 100 && wave.size() != 1; i++) @(negedge clock);
    data_in  = 8'h3C;
    write_en = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
    check("full_pop_count", fifo_count, 3);
    check("full_pop_ready", data_ready, 1);
    wait_idle(1000);
    check("full_busy_len", busy_acc, 5 * 30);

    // Reset in the middle of a data bit, with a word still queued.
    start_frame_test(16'd3, 2'b00, 1'b0);
    write_word(8'hC3);
    write_word(8'h96);
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_tx",    tx,         1);
    check("rstmid_busy",  busy,       0);
    check("rstmid_count", fifo_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    start_frame_test(16'd3, 2'b00, 1'b0);
    write_word(8'h5A);
    wait_idle(200);
    check("rstmid_clean_len", busy_acc, 40);

    // Divider change mid-frame only affects the following frame.
    start_frame_test(16'd3, 2'b00, 1'b0);
    write_word(8'h11);
    write_word(8'h22);
    repeat (6) @(negedge clock);
    clock_divider = 16'd1;
    wait_idle(300);
    check("cfg_change_len", busy_acc, 40 + 20);

    // Random traffic with random configuration changes, including mid-frame.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      write_en = ($urandom_range(0, 2) == 0);
      data_in  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        clock_divider = 16'($urandom_range(0, 3));
        parity_mode   = 2'($urandom);
        stop_bits     = 1'($urandom);
      end
    end
    @(negedge clock);
    write_en = 1'b0;
    wait_idle(5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
